pool_sched_2x2: RTL
===================

Name: pool_sched_2x2

Overview:
Sequencer that runs 2x2, stride-2 pooling over an IMG_H x IMG_W feature map of signed 16-bit pixels held in an external single-port read RAM. It issues the reads and reduces each window, either by averaging or, optionally, by taking the maximum. Results go to an output RAM in row-major order. Sits between the convolution stage's output buffer and the next layer's input buffer, and is started once per feature map by the layer controller.

Parameters:
IMG_W, 28, input map width in pixels (even; an odd trailing column is ignored)
IMG_H, 28, input map height in pixels (even; an odd trailing row is ignored)
DATA_W, 16, pixel width, signed
ADDR_W, 10, address width of both RAM ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that starts a pass; ignored while busy=1
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last write
rd_en  out  1  input RAM read strobe
rd_addr  out  ADDR_W  input RAM address, row-major y*IMG_W+x
rd_data  in  DATA_W  input RAM data, valid one cycle after rd_en
wr_en  out  1  output RAM write strobe
wr_addr  out  ADDR_W  output RAM address, row-major oy*OUT_W+ox
wr_data  out  DATA_W  pooled pixel

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Derived constants: OUT_W=IMG_W/2 and OUT_H=IMG_H/2, both floor.
- Reset: state=IDLE. busy, done, rd_en and wr_en are all 0. rd_addr, wr_addr, wr_data, accumulator and counters are all 0.
- Reset mid-pass: the block returns to IDLE on the next edge. No further reads or writes are issued and done is not pulsed.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: on start=1, load ox=oy=0, clear p and acc, then go to FETCH.
- FETCH: lasts 4 cycles, p=0..3.
  - Address for each p: (2oy+p[1])*IMG_W + 2ox + p[0].
  - rd_en=1 each cycle.
  - For p>0, capture the rd_data of the previous read into acc.
- DRAIN: one cycle. rd_en=0; capture the 4th pixel.
- WRITE: one cycle.
  - wr_en=1, wr_addr=oy*OUT_W+ox, wr_data=reduced value.
  - Advance ox; on wrap (ox==OUT_W-1) set ox=0 and advance oy.
  - If this was the last window go to DONE, else return to FETCH with acc cleared.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- Timing: 6 cycles per output. With start sampled at cycle 0, the first rd_en is at cycle 1 and done is at cycle 1+6*OUT_W*OUT_H.
- Average reduction:
  - acc is a DATA_W+2 bit signed sum.
  - Result is sum/4 truncated toward zero: if sum<0, add 3 before the arithmetic shift right by 2.
  - The result always fits in DATA_W, so no saturation is needed.
- A start pulse that coincides with done is ignored. A start while busy is ignored.
- If OUT_W or OUT_H is 0, start produces done 1 cycle later with no reads and no writes.

Optional Feature:
- Macro: POOL_SCHED_MAX_EN.
- Defined: reduction is the signed maximum of the 4 pixels. acc holds the running max and is seeded with the first pixel, not 0. Timing and addresses are unchanged.
- Undefined: average reduction as described above. No max comparator is synthesised.

Decomposition:
- Package pool_pkg holds:
  - typedef pixel_t (signed DATA_W)
  - enum pool_state_t {IDLE, FETCH, DRAIN, WRITE, DONE}
  - function pool_avg4 (round-toward-zero divide)
- One sub-module, pool_reduce_2x2: the accumulator/reducer. Inputs: clr, capture enable and pixel. Output: reduced value. It contains the average/max selection, which keeps the FSM free of arithmetic.

Test Plan:
1. 4x4 map of pixels 0..15 row-major, average mode: writes 2,4,10,12 at addresses 0..3; done at cycle 25.
2. Window {-1,-2,-3,-4} on a 2x2 map: sum -10, so wr_data=-2 (not -3); window {-1,0,0,0}: wr_data=0.
3. All pixels 32767 (or all -32768) on a 2x2 map: wr_data=32767 (resp. -32768), no overflow.
4. 5x5 map: exactly 4 writes; rows and columns at index 4 are never read (no rd_addr with x==4 or y==4).
5. Start pulse re-asserted mid-pass, then rst asserted after the 2nd write of a 4x4 pass: extra start ignored; after rst no wr_en, busy=0, done=0; a new start completes normally.
6. POOL_SCHED_MAX_EN defined, window {-7,3,-1,2}: wr_data=3; all-negative window {-9,-5,-8,-6}: wr_data=-5.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling sequencer.
// Contents: pixel_t (signed pixel), pool_state_t (sequencer FSM states),
//           pool_avg4 (sum/4 with truncation toward zero).
package pool_pkg;

  localparam int POOL_DATA_W = 16;

  typedef logic signed [POOL_DATA_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } pool_state_t;

  // A plain arithmetic shift rounds toward minus infinity; biasing negative
  // sums by 3 first makes the divide truncate toward zero instead.
  function automatic logic signed [31:0] pool_avg4(input logic signed [31:0] sum);
    logic signed [31:0] adj;
    adj = (sum < 0) ? (sum + 32'sd3) : sum;
    return adj >>> 2;
  endfunction

endpackage

// File: rtl/pool_reduce_2x2.sv
// Window reducer for the pooling sequencer: accumulates 4 pixels, presents the pooled value.
// Ports: clk/rst, clr (start a new window), cap_en (take pix this cycle), pix in, result out.
// Build option POOL_SCHED_MAX_EN: signed maximum instead of round-toward-zero average.
module pool_reduce_2x2
  import pool_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic signed [DATA_W-1:0] pix,
  output logic signed [DATA_W-1:0] result
);

`ifdef POOL_SCHED_MAX_EN

  // Running maximum; the first pixel after clr seeds it so that an
  // all-negative window is not clamped to the cleared value.
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     first_q, first_d;

  always_comb begin
    max_d   = max_q;
    first_d = first_q;
    if (clr) begin
      max_d   = '0;
      first_d = 1'b1;
    end else if (cap_en) begin
      if (first_q || (pix > max_q)) max_d = pix;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q   <= '0;
      first_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      first_q <= first_d;
    end
  end

  assign result = max_q;

`else

  // Two guard bits hold the sum of 4 pixels without overflow.
  logic signed [DATA_W+1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (cap_en) acc_d = acc_q + (DATA_W+2)'(pix);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // |sum/4| never exceeds the pixel range, so truncation to DATA_W is exact.
  assign result = DATA_W'(pool_avg4(32'(acc_q)));

`endif

endmodule

// File: rtl/pool_sched_2x2.sv
// 2x2 stride-2 pooling sequencer: reads windows from the input RAM, writes pooled pixels row-major.
// Ports: start/busy/done handshake, rd_en/rd_addr/rd_data (1-cycle read latency), wr_en/wr_addr/wr_data.
// Build option POOL_SCHED_MAX_EN selects max pooling (see pool_reduce_2x2); 6 cycles per output pixel.
module pool_sched_2x2
  import pool_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam bit EMPTY = (OUT_W == 0) || (OUT_H == 0);

  pool_state_t              state_q, state_d;
  logic [ADDR_W-1:0]        ox_q, ox_d, oy_q, oy_d;
  logic [1:0]               p_q, p_d;
  logic                     red_clr, red_cap;
  logic signed [DATA_W-1:0] red_val;
  logic                     last_col, last_row;

  assign last_col = (ox_q == ADDR_W'(OUT_W - 1));
  assign last_row = (oy_q == ADDR_W'(OUT_H - 1));

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    p_d     = p_q;
    red_clr = 1'b0;
    red_cap = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ox_d    = '0;
          oy_d    = '0;
          p_d     = '0;
          red_clr = 1'b1;
          state_d = EMPTY ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        // p[0] selects the column, p[1] the row inside the window.
        rd_addr = ADDR_W'((2 * oy_q + p_q[1]) * IMG_W + 2 * ox_q + p_q[0]);
        // Read data lags the address by a cycle, so p=0 has nothing to take.
        red_cap = (p_q != 2'd0);
        p_d     = p_q + 2'd1;
        if (p_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        red_cap = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(oy_q * OUT_W + ox_q);
        wr_data = red_val;
        if (last_col) begin
          ox_d = '0;
          oy_d = oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
        if (last_col && last_row) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          red_clr = 1'b1;
          p_d     = '0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      p_q     <= p_d;
    end
  end

  pool_reduce_2x2 #(
    .DATA_W(DATA_W)
  ) u_reduce (
    .clk   (clk),
    .rst   (rst),
    .clr   (red_clr),
    .cap_en(red_cap),
    .pix   (rd_data),
    .result(red_val)
  );

endmodule
